// File: rtl/serial_addsub.sv
// Digit-serial WIDTH-bit adder/subtractor: one DIGIT-bit slice per clock, start/done handshake.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output o_ovf.
module serial_addsub_digit #(
  parameter int DIGIT = 32
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout
);
  logic [DIGIT:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
  assign o_sum  = w_full[DIGIT-1:0];
  assign o_cout = w_full[DIGIT];
endmodule

module serial_addsub #(
  parameter int WIDTH = 256,
  parameter int DIGIT = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_addsub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_done,
  output logic             o_busy
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             o_ovf
`endif
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_acc, r_sum;
  logic             r_carry, r_cout, r_done;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_dig;
  logic             w_dig_cout;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_accept, w_last;

  serial_addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .i_a    (r_a_sr[DIGIT-1:0]),
    .i_b    (r_b_sr[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dig),
    .o_cout (w_dig_cout)
  );

  // New digit enters at the top; after N shifts the LSB digit lands at bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_acc_full
      assign w_acc_nxt = w_dig;
    end else begin : g_acc_shift
      assign w_acc_nxt = {w_dig, r_acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == CW'(N - 1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf, w_ovf;
  // Carry into the MSB is recovered from the top sum bit and its operand bits.
  assign w_ovf = (w_dig[DIGIT-1] ^ r_a_sr[DIGIT-1] ^ r_b_sr[DIGIT-1]) ^ w_dig_cout;
  assign o_ovf = r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_ovf;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Subtract as a + ~b + 1: invert b, seed the carry with 1.
        r_a_sr  <= i_a;
        r_b_sr  <= i_b ^ {WIDTH{i_addsub}};
        r_carry <= i_addsub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sr  <= r_a_sr >> DIGIT;
        r_b_sr  <= r_b_sr >> DIGIT;
        r_acc   <= w_acc_nxt;
        r_carry <= w_dig_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum  <= w_acc_nxt;
          r_cout <= w_dig_cout;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_done = r_done;
  assign o_busy = (r_state == S_RUN);
endmodule
